alu_result_buffer: RTL and testbench

- Downstream stage of the 4-bit ALU. Captures each ALU result beat (result, carry, zero) into an accumulator register and a small result FIFO.
- The accumulator value is fed back as the ALU's operand A, which enables chained operations.
- The FIFO drains to the output pins through a valid/ready handshake.

---
 rtl/alu_result_buffer.sv | 110 +++++++++++
 tb/tb_alu_result_buffer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/alu_result_buffer.sv
// ALU result buffer: accumulator feedback plus a DEPTH-entry result FIFO with valid/ready drain.
// Optional ALU_RB_PARITY_EN stores an even-parity bit per entry and widens out_data to 7 bits.

module alu_rb_slot #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         we,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= '0;
        else if (we) q <= d;
    end
endmodule

module alu_result_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_result,
    input  logic             in_carry,
    input  logic             in_zero,
    input  logic             acc_clear,
    output logic [3:0]       acc_out,
    output logic             carry_sticky,
    output logic [3:0]       beat_cnt,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef ALU_RB_PARITY_EN
    output logic [6:0]       out_data,
`else
    output logic [5:0]       out_data,
`endif
    output logic [PTR_W:0]   fifo_cnt,
    output logic             overflow
);
`ifdef ALU_RB_PARITY_EN
    localparam int DW = 7;
`else
    localparam int DW = 6;
`endif
    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0]            wr_ptr, rd_ptr;
    logic                        push, pop;
    logic [DW-1:0]               wr_entry;
    logic [DEPTH-1:0][DW-1:0]    slot_q;

    // in_ready depends on the registered count only, so a same-cycle pop cannot open a slot
    assign in_ready  = (fifo_cnt != FULL);
    assign out_valid = (fifo_cnt != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

`ifdef ALU_RB_PARITY_EN
    assign wr_entry = {^{in_zero, in_carry, in_result}, in_zero, in_carry, in_result};
`else
    assign wr_entry = {in_zero, in_carry, in_result};
`endif

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        alu_rb_slot #(.W(DW)) u_slot (
            .clk  (clk),
            .rst_n(rst_n),
            .we   (push && (wr_ptr == PTR_W'(i))),
            .d    (wr_entry),
            .q    (slot_q[i])
        );
    end

    assign out_data = out_valid ? slot_q[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_cnt     <= '0;
            overflow     <= 1'b0;
            acc_out      <= '0;
            carry_sticky <= 1'b0;
            beat_cnt     <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (in_valid && !in_ready) overflow <= 1'b1;
            // clear wins over a same-cycle push; the FIFO entry is still written
            if (acc_clear) begin
                acc_out      <= '0;
                carry_sticky <= 1'b0;
                beat_cnt     <= '0;
            end else if (push) begin
                acc_out      <= in_result;
                carry_sticky <= carry_sticky | in_carry;
                if (beat_cnt != 4'hF) beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed bench for alu_result_buffer: vector table plus wrap, saturation, reset and parity sequences.

module tb_alu_result_buffer;
`ifdef ALU_RB_PARITY_EN
    localparam int ODW = 7;
`else
    localparam int ODW = 6;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid, in_ready, in_carry, in_zero, acc_clear;
    logic [3:0]     in_result, acc_out, beat_cnt;
    logic           carry_sticky, out_valid, out_ready, overflow;
    logic [ODW-1:0] out_data;
    logic [2:0]     fifo_cnt;

    int checks = 0;
    int errors = 0;

    alu_result_buffer #(.DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_carry(in_carry), .in_zero(in_zero),
        .acc_clear(acc_clear), .acc_out(acc_out), .carry_sticky(carry_sticky),
        .beat_cnt(beat_cnt), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .fifo_cnt(fifo_cnt), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [3:0] res;
        logic       c, z, clr, ordy;
        logic [3:0] acc;
        logic       cs;
        logic [3:0] bc;
        logic [2:0] fc;
        logic       ovld;
        logic [5:0] data;
        logic       irdy, ovf;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] res, input logic c, input logic z,
                         input logic clr, input logic ordy);
        in_valid = v; in_result = res; in_carry = c; in_zero = z;
        acc_clear = clr; out_ready = ordy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_data(input string name, input logic [5:0] exp);
        chk(name, 8'(out_data[5:0]), 8'(exp));
`ifdef ALU_RB_PARITY_EN
        chk({name, "_par"}, 8'(out_data[6]), 8'(^exp));
`endif
    endtask

    logic [3:0] q[$];

    initial begin
        //          v  res   c  z  clr ordy  acc  cs  bc   fc ovld data   irdy ovf
        tbl[0]  = '{1, 4'hA, 1, 0, 0, 0,   4'hA, 1, 4'd1, 1, 1, 6'h1A, 1, 0};
        tbl[1]  = '{0, 4'h0, 0, 0, 0, 1,   4'hA, 1, 4'd1, 0, 0, 6'h00, 1, 0};
        tbl[2]  = '{0, 4'h0, 0, 0, 1, 0,   4'h0, 0, 4'd0, 0, 0, 6'h00, 1, 0};
        tbl[3]  = '{1, 4'h1, 0, 0, 0, 0,   4'h1, 0, 4'd1, 1, 1, 6'h01, 1, 0};
        tbl[4]  = '{1, 4'h2, 0, 0, 0, 0,   4'h2, 0, 4'd2, 2, 1, 6'h01, 1, 0};
        tbl[5]  = '{1, 4'h3, 0, 0, 0, 0,   4'h3, 0, 4'd3, 3, 1, 6'h01, 1, 0};
        tbl[6]  = '{1, 4'h4, 0, 0, 0, 0,   4'h4, 0, 4'd4, 4, 1, 6'h01, 0, 0};
        tbl[7]  = '{1, 4'h5, 0, 0, 0, 0,   4'h4, 0, 4'd4, 4, 1, 6'h01, 0, 1};
        tbl[8]  = '{1, 4'h6, 0, 0, 0, 1,   4'h4, 0, 4'd4, 3, 1, 6'h02, 1, 1};
        tbl[9]  = '{0, 4'h0, 0, 0, 0, 1,   4'h4, 0, 4'd4, 2, 1, 6'h03, 1, 1};
        tbl[10] = '{0, 4'h0, 0, 0, 0, 1,   4'h4, 0, 4'd4, 1, 1, 6'h04, 1, 1};
        tbl[11] = '{0, 4'h0, 0, 0, 0, 1,   4'h4, 0, 4'd4, 0, 0, 6'h00, 1, 1};
        tbl[12] = '{1, 4'h7, 1, 0, 1, 0,   4'h0, 0, 4'd0, 1, 1, 6'h17, 1, 1};
        tbl[13] = '{0, 4'h0, 0, 0, 0, 1,   4'h0, 0, 4'd0, 0, 0, 6'h00, 1, 1};
        tbl[14] = '{1, 4'h0, 0, 1, 0, 0,   4'h0, 0, 4'd1, 1, 1, 6'h20, 1, 1};
        tbl[15] = '{1, 4'h5, 0, 0, 0, 1,   4'h5, 0, 4'd2, 1, 1, 6'h05, 1, 1};
        tbl[16] = '{0, 4'h0, 0, 0, 0, 1,   4'h5, 0, 4'd2, 0, 0, 6'h00, 1, 1};

        rst_n = 1'b0;
        drive(0, 4'h0, 0, 0, 0, 0);
        #12;
        chk("rst_acc", 8'(acc_out), 8'h0);
        chk("rst_fc", 8'(fifo_cnt), 8'h0);
        chk("rst_ovld", 8'(out_valid), 8'h0);
        chk("rst_irdy", 8'(in_ready), 8'h1);
        chk("rst_ovf", 8'(overflow), 8'h0);
        chk("rst_bc", 8'(beat_cnt), 8'h0);
        chk_data("rst_data", 6'h00);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].v, tbl[i].res, tbl[i].c, tbl[i].z, tbl[i].clr, tbl[i].ordy);
            step();
            chk($sformatf("v%0d_acc", i), 8'(acc_out), 8'(tbl[i].acc));
            chk($sformatf("v%0d_cs", i), 8'(carry_sticky), 8'(tbl[i].cs));
            chk($sformatf("v%0d_bc", i), 8'(beat_cnt), 8'(tbl[i].bc));
            chk($sformatf("v%0d_fc", i), 8'(fifo_cnt), 8'(tbl[i].fc));
            chk($sformatf("v%0d_ovld", i), 8'(out_valid), 8'(tbl[i].ovld));
            chk_data($sformatf("v%0d_data", i), tbl[i].data);
            chk($sformatf("v%0d_irdy", i), 8'(in_ready), 8'(tbl[i].irdy));
            chk($sformatf("v%0d_ovf", i), 8'(overflow), 8'(tbl[i].ovf));
        end

        // steady push+pop at occupancy 2 across pointer wrap
        drive(1, 4'h1, 0, 0, 0, 0); step();
        drive(1, 4'h2, 0, 0, 0, 0); step();
        q = '{4'h1, 4'h2};
        chk("wrap_pre_fc", 8'(fifo_cnt), 8'd2);
        for (int k = 0; k < 8; k++) begin
            drive(1, 4'(k + 3), 0, 0, 0, 1);
            step();
            void'(q.pop_front());
            q.push_back(4'(k + 3));
            chk($sformatf("wrap%0d_fc", k), 8'(fifo_cnt), 8'd2);
            chk_data($sformatf("wrap%0d_data", k), {2'b00, q[0]});
        end

        // drain, clear, then 17 pushes while draining
        drive(0, 4'h0, 0, 0, 0, 1);
        repeat (3) step();
        chk("drain_fc", 8'(fifo_cnt), 8'd0);
        drive(0, 4'h0, 0, 0, 1, 1); step();
        chk("clr_bc", 8'(beat_cnt), 8'd0);
        for (int k = 0; k < 17; k++) begin
            drive(1, 4'(k), 1'(k == 16), 0, 0, 1);
            step();
            chk($sformatf("sat%0d_bc", k), 8'(beat_cnt), 8'((k + 1 > 15) ? 15 : k + 1));
            chk($sformatf("sat%0d_fc", k), 8'(fifo_cnt), 8'd1);
        end
        chk("sat_cs", 8'(carry_sticky), 8'h1);
        chk("sat_acc", 8'(acc_out), 8'h0);

        // asynchronous reset mid-drain at occupancy 3
        drive(0, 4'h0, 0, 0, 0, 1); step();
        drive(1, 4'h9, 0, 0, 0, 0);
        repeat (4) step();
        drive(0, 4'h0, 0, 0, 0, 1); step();
        chk("mid_fc", 8'(fifo_cnt), 8'd3);
        chk("mid_irdy", 8'(in_ready), 8'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ovld", 8'(out_valid), 8'h0);
        chk("arst_fc", 8'(fifo_cnt), 8'd0);
        chk("arst_acc", 8'(acc_out), 8'h0);
        chk("arst_irdy", 8'(in_ready), 8'h1);
        chk("arst_ovf", 8'(overflow), 8'h0);
        chk_data("arst_data", 6'h00);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 4'h0, 0, 0, 0, 0); step();
        chk("post_rst_fc", 8'(fifo_cnt), 8'd0);

        drive(1, 4'h3, 0, 0, 0, 0); step();
        chk_data("par03", 6'h03);
        drive(0, 4'h0, 0, 0, 0, 1); step();
        drive(1, 4'h1, 0, 0, 0, 0); step();
        chk_data("par01", 6'h01);
        drive(0, 4'h0, 0, 0, 0, 0); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
